// File: rtl/mips_pkg.sv
// Shared types and widths for the MIPS instruction-memory boot loader.
// Imported by the loader FSM and its byte-to-word packer.
package mips_pkg;

    localparam int MIPS_WORD_W = 32;
    localparam int LOAD_CNT_W  = 16;

    typedef enum logic [2:0] {
        LD_IDLE   = 3'd0,
        LD_HDR_HI = 3'd1,
        LD_HDR_LO = 3'd2,
        LD_DATA   = 3'd3,
        LD_WRITE  = 3'd4,
        LD_DONE   = 3'd5,
        LD_ERR    = 3'd6
    } ld_state_e;

endpackage

// File: rtl/mips_word_packer.sv
// Packs four stream bytes, MSB first, into one 32-bit instruction word.
// word_full flags the shift that completes the word.
module mips_word_packer
    import mips_pkg::*;
(
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic                   clear,
    input  logic                   shift_en,
    input  logic [7:0]             byte_in,
    output logic [MIPS_WORD_W-1:0] word,
    output logic                   word_full
);

    logic [1:0] byte_idx;

    assign word_full = shift_en && (byte_idx == 2'd3);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            word     <= '0;
            byte_idx <= '0;
        end else if (clear) begin
            word     <= '0;
            byte_idx <= '0;
        end else if (shift_en) begin
            word     <= {word[MIPS_WORD_W-9:0], byte_in};
            byte_idx <= byte_idx + 2'd1;
        end
    end

endmodule

// File: rtl/mips_imem_loader.sv
// Boot-time instruction-memory writer: header word count, then packed words
// written to consecutive addresses while the core is held at PC 0.
module mips_imem_loader
    import mips_pkg::*;
#(
    parameter int ADDR_WIDTH = 10
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic                   start,
    input  logic [7:0]             in_data,
    input  logic                   in_valid,
    output logic                   in_ready,
    output logic                   mem_we,
    output logic [ADDR_WIDTH-1:0]  mem_addr,
    output logic [MIPS_WORD_W-1:0] mem_wdata,
    output logic                   core_hold,
    output logic                   done,
    output logic                   error,
    output logic [LOAD_CNT_W-1:0]  words_loaded
);

    localparam int unsigned MAX_WORDS = 32'd1 << ADDR_WIDTH;

    ld_state_e             state;
    ld_state_e             state_nxt;
    logic [7:0]            n_hi;
    logic [LOAD_CNT_W-1:0] n_words;
    logic [LOAD_CNT_W-1:0] n_rx;
    logic [LOAD_CNT_W-1:0] wl_inc;
    logic                  xfer;
    logic                  start_ok;
    logic                  pk_clear;
    logic                  pk_shift;
    logic                  pk_full;

    assign xfer     = in_valid & in_ready;
    assign start_ok = start && (state == LD_IDLE ||
                                state == LD_DONE ||
                                state == LD_ERR);
    assign n_rx     = {n_hi, in_data};
    assign wl_inc   = words_loaded + 16'd1;
    assign pk_shift = xfer && (state == LD_DATA);
    assign pk_clear = start_ok || (state == LD_WRITE);

    mips_word_packer u_packer (
        .clock     (clock),
        .reset_n   (reset_n),
        .clear     (pk_clear),
        .shift_en  (pk_shift),
        .byte_in   (in_data),
        .word      (mem_wdata),
        .word_full (pk_full)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            LD_IDLE, LD_DONE, LD_ERR:
                if (start_ok) state_nxt = LD_HDR_HI;
            LD_HDR_HI:
                if (xfer) state_nxt = LD_HDR_LO;
            LD_HDR_LO:
                if (xfer) begin
                    if (n_rx == '0)
                        state_nxt = LD_DONE;
                    else if (32'(n_rx) > MAX_WORDS)
                        state_nxt = LD_ERR;
                    else
                        state_nxt = LD_DATA;
                end
            LD_DATA:
                if (pk_full) state_nxt = LD_WRITE;
            LD_WRITE:
                state_nxt = (wl_inc == n_words) ? LD_DONE : LD_DATA;
            default:
                state_nxt = LD_IDLE;
        endcase
    end

    // Outputs are decoded from the next state so each one is a plain flop.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state        <= LD_IDLE;
            in_ready     <= 1'b0;
            mem_we       <= 1'b0;
            core_hold    <= 1'b1;
            done         <= 1'b0;
            error        <= 1'b0;
            n_hi         <= '0;
            n_words      <= '0;
            words_loaded <= '0;
            mem_addr     <= '0;
        end else begin
            state     <= state_nxt;
            in_ready  <= (state_nxt == LD_HDR_HI) ||
                         (state_nxt == LD_HDR_LO) ||
                         (state_nxt == LD_DATA);
            mem_we    <= (state_nxt == LD_WRITE);
            core_hold <= (state_nxt != LD_DONE);
            done      <= (state_nxt == LD_DONE);
            error     <= (state_nxt == LD_ERR);
            if (state == LD_HDR_HI && xfer)
                n_hi <= in_data;
            if (start_ok)
                n_words <= '0;
            else if (state == LD_HDR_LO && xfer)
                n_words <= n_rx;
            if (start_ok) begin
                words_loaded <= '0;
                mem_addr     <= '0;
            end else begin
                if (state == LD_WRITE)
                    words_loaded <= wl_inc;
                if (state_nxt == LD_WRITE)
                    mem_addr <= words_loaded[ADDR_WIDTH-1:0];
            end
        end
    end

endmodule

// File: tb/tb_mips_imem_loader.sv
// Bench for mips_imem_loader: image scoreboard plus directed load scenarios.
module tb_mips_imem_loader;

    localparam int AW = 10;

    logic          clock = 1'b0;
    logic          reset_n = 1'b0;
    logic          start = 1'b0;
    logic [7:0]    in_data = 8'h00;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic          core_hold;
    logic          done;
    logic          error;
    logic [15:0]   words_loaded;

    mips_imem_loader #(.ADDR_WIDTH(AW)) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .start        (start),
        .in_data      (in_data),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .core_hold    (core_hold),
        .done         (done),
        .error        (error),
        .words_loaded (words_loaded)
    );

    always #5 clock = ~clock;

    int          n_cmp = 0;
    int          n_fail = 0;
    bit          chk_en = 1'b0;
    bit          exp_done_next = 1'b0;
    int          m_cnt = 0;
    int          m_n = 0;
    int          img_n = 0;
    int          img_words = 0;
    int          last_addr = -1;
    logic [31:0] last_data = '0;
    int unsigned ea;
    logic [31:0] ed;

    logic [7:0]  tx_q[$];
    int unsigned exp_a[$];
    logic [31:0] exp_d[$];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Model: each start expects exactly the image words, in order, at 0..N-1.
    always @(posedge clock) begin
        #1;
        if (chk_en && reset_n) begin
            if (exp_done_next) begin
                chk("done_after_last", done, 1);
                chk("hold_after_last", core_hold, 0);
                exp_done_next = 1'b0;
            end
            chk("words_loaded", words_loaded, m_cnt);
            chk("hold_vs_done", core_hold, !done);
            if (mem_we) begin
                chk("ready_in_write", in_ready, 0);
                if (exp_a.size() == 0) begin
                    chk("spurious_we", mem_we, 0);
                end else begin
                    ea = exp_a.pop_front();
                    ed = exp_d.pop_front();
                    chk("wr_addr", mem_addr, ea);
                    chk("wr_data", mem_wdata, ed);
                    last_addr = mem_addr;
                    last_data = mem_wdata;
                    m_cnt++;
                    if (m_cnt == m_n) exp_done_next = 1'b1;
                end
            end
        end
    end

    task automatic new_image(input int n);
        tx_q.delete();
        exp_a.delete();
        exp_d.delete();
        tx_q.push_back(n[15:8]);
        tx_q.push_back(n[7:0]);
        img_n = n;
        img_words = 0;
    endtask

    task automatic add_word(input logic [31:0] w);
        tx_q.push_back(w[31:24]);
        tx_q.push_back(w[23:16]);
        tx_q.push_back(w[15:8]);
        tx_q.push_back(w[7:0]);
        exp_a.push_back(img_words);
        exp_d.push_back(w);
        img_words++;
    endtask

    task automatic do_start();
        @(negedge clock);
        start = 1'b1;
        m_cnt = 0;
        m_n = img_n;
        exp_done_next = 1'b0;
        @(negedge clock);
        start = 1'b0;
    endtask

    task automatic send(input bit rnd, input int start_at);
        int idx = 0;
        int budget = 0;
        while (idx < tx_q.size()) begin
            @(negedge clock);
            start = 1'b0;
            if (budget++ > 30000) begin
                chk("send_timeout", idx, tx_q.size());
                break;
            end
            in_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            in_data  = in_valid ? tx_q[idx] : 8'($urandom);
            if (idx == start_at && in_ready) start = 1'b1;
            if (in_valid && in_ready) idx++;
        end
        @(negedge clock);
        in_valid = 1'b0;
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int c = 0;
        while (!done && !error && c < budget) begin
            @(negedge clock);
            c++;
        end
        chk("load_done", done, 1);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_in_ready"}, in_ready, 0);
        chk({tag, "_mem_we"}, mem_we, 0);
        chk({tag, "_mem_addr"}, mem_addr, 0);
        chk({tag, "_mem_wdata"}, mem_wdata, 0);
        chk({tag, "_core_hold"}, core_hold, 1);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_error"}, error, 0);
        chk({tag, "_words"}, words_loaded, 0);
    endtask

    initial begin
        repeat (3) @(negedge clock);
        chk_reset_vals("rst");
        reset_n = 1'b1;
        @(negedge clock);
        chk_en = 1'b1;

        // Nominal two-word load
        new_image(2);
        add_word(32'h20080005);
        add_word(32'h08000000);
        do_start();
        chk("nom_hold", core_hold, 1);
        chk("nom_ready", in_ready, 1);
        send(1'b0, -1);
        wait_done(50);
        chk("nom_words", words_loaded, 2);
        chk("nom_hold_rel", core_hold, 0);
        chk("nom_last_addr", last_addr, 1);
        chk("nom_last_data", last_data, 32'h08000000);
        chk("nom_pending", exp_a.size(), 0);
        chk("nom_ready_done", in_ready, 0);

        // Same image with random stalls
        new_image(2);
        add_word(32'h20080005);
        add_word(32'h08000000);
        do_start();
        send(1'b1, -1);
        wait_done(200);
        chk("bp_words", words_loaded, 2);
        chk("bp_pending", exp_a.size(), 0);

        // Empty image
        new_image(0);
        do_start();
        send(1'b0, -1);
        chk("n0_done", done, 1);
        chk("n0_hold", core_hold, 0);
        chk("n0_words", words_loaded, 0);

        // Oversized header N=1025
        new_image(1025);
        do_start();
        send(1'b0, -1);
        chk("ovf_error", error, 1);
        chk("ovf_ready", in_ready, 0);
        chk("ovf_we", mem_we, 0);
        chk("ovf_hold", core_hold, 1);
        chk("ovf_done", done, 0);
        in_valid = 1'b1;
        in_data = 8'h5a;
        repeat (3) @(negedge clock);
        in_valid = 1'b0;
        chk("ovf_error_held", error, 1);
        chk("ovf_ready_held", in_ready, 0);
        new_image(1);
        add_word(32'h3c011234);
        do_start();
        chk("ovf_err_clr", error, 0);
        send(1'b0, -1);
        wait_done(50);
        chk("ovf_reload_err", error, 0);
        chk("ovf_reload_addr", last_addr, 0);
        chk("ovf_reload_data", last_data, 32'h3c011234);

        // Reset after two data bytes
        new_image(1);
        add_word(32'hAABBCCDD);
        void'(tx_q.pop_back());
        void'(tx_q.pop_back());
        exp_a.delete();
        exp_d.delete();
        do_start();
        send(1'b0, -1);
        chk_en = 1'b0;
        #2 reset_n = 1'b0;
        #1 chk_reset_vals("midrst");
        @(negedge clock);
        reset_n = 1'b1;
        m_cnt = 0;
        m_n = 0;
        exp_done_next = 1'b0;
        chk_en = 1'b1;
        repeat (2) @(negedge clock);
        chk("midrst_idle_ready", in_ready, 0);
        chk("midrst_idle_hold", core_hold, 1);
        new_image(1);
        add_word(32'h0000000C);
        do_start();
        send(1'b0, -1);
        wait_done(50);
        chk("midrst_addr", last_addr, 0);
        chk("midrst_data", last_data, 32'h0000000C);
        chk("midrst_words", words_loaded, 1);

        // start pulsed inside DATA is ignored
        new_image(2);
        add_word(32'h11223344);
        add_word(32'h55667788);
        do_start();
        send(1'b0, 4);
        wait_done(50);
        chk("ign_words", words_loaded, 2);
        chk("ign_pending", exp_a.size(), 0);
        chk("ign_last_data", last_data, 32'h55667788);

        // Full-depth image
        new_image(1024);
        for (int i = 0; i < 1024; i++)
            add_word({16'(i), ~16'(i)});
        do_start();
        send(1'b0, -1);
        wait_done(100);
        chk("full_last_addr", last_addr, 1023);
        chk("full_last_data", last_data, 32'h03FFFC00);
        chk("full_words", words_loaded, 1024);
        chk("full_pending", exp_a.size(), 0);
        chk("full_error", error, 0);

        repeat (2) @(negedge clock);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_fail);
        $finish;
    end

endmodule
